mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one shift-add multiplier unit (start/idle/done handshake, 2N-bit product) between two requesters.
//  Round-robin arbitration; latches the winner's operands, pulses the multiplier start, waits for done, returns the product.
//  A watchdog ends a transaction whose done never arrives and flags an error.
//  Sits between the two requesting units and the multiplier datapath+control pair.
// PARAMETERS
//  N        4   operand width; product is 2N bits
//  MAX_CYC  64  max cycles in BUSY before timeout (>=2)
// PORTS
//  Clk       in   1   clock, all state updates on rising edge
//  Rst       in   1   synchronous, active-high reset
//  Req0      in   1   requester 0 wants a multiply; held high until Ack0
//  A0, B0    in   N   requester 0 multiplicand / multiplier, valid while Req0=1
//  Ack0      out  1   1-cycle pulse: request 0 accepted, operands latched
//  Valid0    out  1   1-cycle pulse: Result belongs to requester 0
//  Req1, A1, B1, Ack1, Valid1   same as port 0, for requester 1
//  Result    out  2N  product of the completed transaction (shared bus)
//  Err       out  1   qualifies Valid0/Valid1: 1 = timed out, Result=0
//  Mul_St    out  1   multiplier start, 1-cycle pulse
//  Mul_A     out  N   multiplicand to multiplier, held for whole transaction
//  Mul_B     out  N   multiplier operand, held for whole transaction
//  Mul_Idle  in   1   multiplier in its idle state
//  Mul_Done  in   1   multiplier completion pulse
//  Mul_P     in   2N  multiplier product, valid when Mul_Done=1
// BEHAVIOUR
//  Reset: state=IDLE; Ack0/1, Valid0/1, Err, Mul_St=0; Result, Mul_A, Mul_B=0; watchdog=0; Last=1 (port 0 wins first tie).
//  FSM (registered state; all outputs registered or decoded from state + regs only):
//   IDLE : if Mul_Idle=1 and (Req0|Req1): pick winner W; Mul_A<=A_W, Mul_B<=B_W, Own<=W;
//          Ack_W=1 next cycle; ->START. Mul_Idle=0 or no Req: stay, no Ack.
//          Arbitration: single requester wins; both -> port != Last.
//   START: Mul_St=1 exactly this cycle; watchdog<=0; ->BUSY.
//   BUSY : Mul_Done=1 -> Result<=Mul_P, Err<=0, ->RESP.
//          Else watchdog+1; watchdog reaches MAX_CYC-1 without done -> Result<=0, Err<=1, ->RESP.
//          Mul_Done and timeout in same cycle: done wins (Err=0).
//   RESP : Valid_Own=1 for this cycle only; Last<=Own; ->IDLE.
//  Ack_W is high during the START cycle (1 cycle after acceptance); Valid_W during RESP.
//  Result and Err hold their value after RESP until the next RESP.
//  Latency, request to Mul_St: 1 cycle after the accepting IDLE edge.
//  Latency, Mul_Done to Valid: 1 cycle. Minimum IDLE->IDLE turnaround: 4 cycles + multiplier time.
//  A Req still high during RESP/IDLE is a new request; the requester drops Req the cycle after Ack.
//  Mul_Done outside BUSY is ignored. Req/operand changes after acceptance have no effect.
//  Mul_A/Mul_B change only on acceptance; stable from START through RESP.
//  Product width: Result = Mul_P unmodified (2N bits); no truncation.
//  Rst mid-transaction: immediate return to reset values; in-flight result discarded; no Valid issued.
//  Watchdog width: clog2(MAX_CYC) bits, saturates, never wraps.
// TESTING
//  1. Req0=1,A0=3,B0=5 alone -> Ack0 pulse, Mul_St 1 cycle with Mul_A=3,Mul_B=5; model done -> Valid0, Result=15, Err=0.
//  2. Req0=Req1=1 right after reset -> port 0 served first, then port 1; exactly one Ack per port, Valid order 0 then 1.
//  3. Both held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; no port starved.
//  4. Max operands A1=15,B1=15 (N=4) -> Result=225 (8'hE1), Valid1.
//  5. Model never asserts Mul_Done -> Valid_Own exactly MAX_CYC cycles after START; Err=1, Result=0.
//  6. Rst during BUSY, then Mul_Done pulse -> all outputs 0, no Valid; next Req0 is served normally.
//  7. Req0=1 while Mul_Idle=0 -> no Ack0 until Mul_Idle=1.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one shift-add multiplier between two requesters,
// with a watchdog that ends a transaction whose Mul_Done never arrives.
module mult_arbiter #(
  parameter int N       = 4,
  parameter int MAX_CYC = 64
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Req0,
  input  logic [N-1:0]   A0,
  input  logic [N-1:0]   B0,
  output logic           Ack0,
  output logic           Valid0,
  input  logic           Req1,
  input  logic [N-1:0]   A1,
  input  logic [N-1:0]   B1,
  output logic           Ack1,
  output logic           Valid1,
  output logic [2*N-1:0] Result,
  output logic           Err,
  output logic           Mul_St,
  output logic [N-1:0]   Mul_A,
  output logic [N-1:0]   Mul_B,
  input  logic           Mul_Idle,
  input  logic           Mul_Done,
  input  logic [2*N-1:0] Mul_P,
  output logic [1:0]     dbg_state
);

  // Handshake: Req/A/B are held until the one-cycle Ack pulse, which coincides
  // with Mul_St; Valid pulses once per accepted request, Err qualifies it.

  localparam int WD_W = $clog2(MAX_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              own_q, own_d;
  logic              last_q, last_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [2*N-1:0]    result_q, result_d;
  logic              err_q, err_d;
  logic [N-1:0]      mul_a_q, mul_a_d;
  logic [N-1:0]      mul_b_q, mul_b_d;

  logic              grant1;
  logic [WD_W-1:0]   wd_inc;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      wd_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      last_q   <= last_d;
      wd_q     <= wd_d;
      result_q <= result_d;
      err_q    <= err_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  // On a tie the port that was not served last wins.
  assign grant1 = Req1 && (!Req0 || !last_q);
  assign wd_inc = (wd_q == WD_LAST) ? wd_q : wd_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    wd_d     = wd_q;
    result_d = result_q;
    err_d    = err_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    unique case (state_q)
      S_IDLE: begin
        if (Mul_Idle && (Req0 || Req1)) begin
          own_d   = grant1;
          mul_a_d = grant1 ? A1 : A0;
          mul_b_d = grant1 ? B1 : B0;
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (Mul_Done) begin
          result_d = Mul_P;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WD_LAST) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_RESP: begin
        last_d  = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Mul_St    = (state_q == S_START);
    Ack0      = (state_q == S_START) && !own_q;
    Ack1      = (state_q == S_START) &&  own_q;
    Valid0    = (state_q == S_RESP)  && !own_q;
    Valid1    = (state_q == S_RESP)  &&  own_q;
    Result    = result_q;
    Err       = err_q;
    Mul_A     = mul_a_q;
    Mul_B     = mul_b_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: directed requests, a behavioural multiplier
// model, and monitors that check start/ack and response events against queues.
module tb_mult_arbiter;

  localparam int N       = 4;
  localparam int MAX_CYC = 8;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic           Req0 = 1'b0, Req1 = 1'b0;
  logic [N-1:0]   A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic           Ack0, Ack1, Valid0, Valid1, Err, Mul_St;
  logic [2*N-1:0] Result;
  logic [N-1:0]   Mul_A, Mul_B;
  logic           Mul_Idle, Mul_Done;
  logic [2*N-1:0] Mul_P;
  logic [1:0]     dbg_state;

  mult_arbiter #(.N(N), .MAX_CYC(MAX_CYC)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .A0(A0), .B0(B0), .Ack0(Ack0), .Valid0(Valid0),
    .Req1(Req1), .A1(A1), .B1(B1), .Ack1(Ack1), .Valid1(Valid1),
    .Result(Result), .Err(Err),
    .Mul_St(Mul_St), .Mul_A(Mul_A), .Mul_B(Mul_B),
    .Mul_Idle(Mul_Idle), .Mul_Done(Mul_Done), .Mul_P(Mul_P),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // multiplier model: not reset by Rst, so an in-flight Mul_Done can arrive after it
  logic           mdl_busy = 1'b0;
  int             mdl_cnt = 0;
  logic [2*N-1:0] mdl_p = '0;
  int             mdl_lat = 2;
  logic           mdl_hang = 1'b0;
  logic           idle_block = 1'b0;

  always @(posedge Clk) begin
    if (!mdl_busy) begin
      if (Mul_St) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= mdl_lat;
        mdl_p    <= {{N{1'b0}}, Mul_A} * {{N{1'b0}}, Mul_B};
      end
    end else if (mdl_cnt == 0) begin
      mdl_busy <= 1'b0;
    end else begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end
  assign Mul_Done = mdl_busy && (mdl_cnt == 0) && !mdl_hang;
  assign Mul_Idle = !mdl_busy && !idle_block;
  assign Mul_P    = mdl_p;

  // scoreboard
  logic [8:0] op_q[$];   // {port, a, b}
  logic [9:0] exp_q[$];  // {port, err, result}
  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int st_cyc = 0;
  logic chk_lat = 1'b0;
  logic [8:0] op_e;
  logic [9:0] res_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst) begin
      if (Mul_St || Ack0 || Ack1) begin
        if (op_q.size() == 0) begin
          check("unexpected_start", 32'(Mul_St), 32'd0);
        end else begin
          op_e = op_q.pop_front();
          check("start_ack", {19'd0, Mul_St, Ack1, Ack0, Mul_A, Mul_B},
                {19'd0, 1'b1, op_e[8], !op_e[8], op_e[7:4], op_e[3:0]});
          st_cyc = cyc;
        end
      end
      if (Valid0 || Valid1) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {30'd0, Valid1, Valid0}, 32'd0);
        end else begin
          res_e = exp_q.pop_front();
          check("resp", {20'd0, Valid0 && Valid1, Valid1, Err, Result}, {22'd0, res_e});
          if (chk_lat) check("timeout_latency", 32'(cyc - st_cyc), 32'(MAX_CYC));
        end
      end
    end
  end

  // driver tasks
  task automatic push(input logic p, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic e, input logic [2*N-1:0] r);
    op_q.push_back({p, a, b});
    exp_q.push_back({p, e, r});
  endtask

  task automatic do_req(input int p, input logic [N-1:0] a, input logic [N-1:0] b);
    int n = 0;
    logic seen = 1'b0;
    if (p == 0) begin Req0 = 1'b1; A0 = a; B0 = b; end
    else        begin Req1 = 1'b1; A1 = a; B1 = b; end
    while (!seen && n < 400) begin
      @(negedge Clk);
      n++;
      seen = (p == 0) ? Ack0 : Ack1;
    end
    if (!seen) check("ack_wait", 32'(seen), 32'd1);
    if (p == 0) Req0 = 1'b0; else Req1 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0) && n < 400) begin
      @(negedge Clk);
      n++;
    end
    check("drain", 32'(exp_q.size() + op_q.size()), 32'd0);
    repeat (2) @(negedge Clk);
  endtask

  task automatic pulse_reset();
    @(posedge Clk); #1 Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
  endtask

  initial begin
    int acks;
    int vbefore;
    repeat (3) @(negedge Clk);
    check("rst_outputs", {24'd0, Ack0, Ack1, Valid0, Valid1, Err, Mul_St, dbg_state}, 32'd0);
    check("rst_regs", {16'd0, Result, Mul_A, Mul_B}, 32'd0);
    @(posedge Clk); #1 Rst = 1'b0;

    // single request 3*5
    push(1'b0, 4'd3, 4'd5, 1'b0, 8'd15);
    do_req(0, 4'd3, 4'd5);
    wait_drain();
    repeat (3) @(negedge Clk);
    check("result_hold", {23'd0, Err, Result}, 32'd15);

    // simultaneous requests right after reset: port 0 then port 1
    pulse_reset();
    push(1'b0, 4'd2, 4'd4, 1'b0, 8'd8);
    push(1'b1, 4'd3, 4'd3, 1'b0, 8'd9);
    fork
      do_req(0, 4'd2, 4'd4);
      do_req(1, 4'd3, 4'd3);
    join
    wait_drain();

    // both ports keep requesting: grants alternate
    push(1'b0, 4'd1,  4'd2,  1'b0, 8'd2);
    push(1'b1, 4'd7,  4'd8,  1'b0, 8'd56);
    push(1'b0, 4'd3,  4'd4,  1'b0, 8'd12);
    push(1'b1, 4'd9,  4'd10, 1'b0, 8'd90);
    push(1'b0, 4'd5,  4'd6,  1'b0, 8'd30);
    push(1'b1, 4'd11, 4'd12, 1'b0, 8'd132);
    fork
      begin
        do_req(0, 4'd1, 4'd2); @(posedge Clk); #1;
        do_req(0, 4'd3, 4'd4); @(posedge Clk); #1;
        do_req(0, 4'd5, 4'd6);
      end
      begin
        do_req(1, 4'd7, 4'd8);   @(posedge Clk); #1;
        do_req(1, 4'd9, 4'd10);  @(posedge Clk); #1;
        do_req(1, 4'd11, 4'd12);
      end
    join
    wait_drain();

    // multiplier never finishes: watchdog timeout
    mdl_hang = 1'b1; mdl_lat = 20; chk_lat = 1'b1;
    push(1'b0, 4'd7, 4'd9, 1'b1, 8'd0);
    do_req(0, 4'd7, 4'd9);
    wait_drain();
    chk_lat = 1'b0; mdl_hang = 1'b0; mdl_lat = 3;

    // maximum operands on port 1
    push(1'b1, 4'd15, 4'd15, 1'b0, 8'hE1);
    do_req(1, 4'd15, 4'd15);
    wait_drain();

    // reset while BUSY; the late Mul_Done must be ignored
    mdl_lat = 6;
    op_q.push_back({1'b0, 4'd2, 4'd3});
    do_req(0, 4'd2, 4'd3);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("busy_before_rst", 32'(dbg_state), 32'd2);
    vbefore = valid_cnt;
    Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    check("rst_mid_outputs", {24'd0, Ack0, Ack1, Valid0, Valid1, Err, Mul_St, dbg_state}, 32'd0);
    check("rst_mid_regs", {16'd0, Result, Mul_A, Mul_B}, 32'd0);
    repeat (12) @(negedge Clk);
    check("no_valid_after_rst", 32'(valid_cnt - vbefore), 32'd0);
    mdl_lat = 2;
    push(1'b0, 4'd6, 4'd7, 1'b0, 8'd42);
    do_req(0, 4'd6, 4'd7);
    wait_drain();

    // multiplier not idle: request must wait
    idle_block = 1'b1;
    push(1'b0, 4'd5, 4'd5, 1'b0, 8'd25);
    Req0 = 1'b1; A0 = 4'd5; B0 = 4'd5;
    acks = 0;
    repeat (6) begin
      @(negedge Clk);
      if (Ack0) acks++;
    end
    check("no_ack_while_busy_mul", 32'(acks), 32'd0);
    check("idle_while_blocked", 32'(dbg_state), 32'd0);
    idle_block = 1'b0;
    do_req(0, 4'd5, 4'd5);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
